// File: rtl/sub32_serial_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and slice width.
package sub32_serial_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub32_serial_cla4.sv
// 4-bit carry-lookahead adder slice: s,co = a + b + ci.
module cla4
    import sub32_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    always_comb begin
        p = a ^ b;
        g = a & b;
        // Every carry is flattened to generate/propagate terms of the slice inputs.
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s  = p ^ c[SLICE_W-1:0];
        co = c[SLICE_W];
    end

endmodule

// File: rtl/sub32_serial.sv
// Multi-cycle subtractor diff = a - b - bin, one 4-bit CLA slice per cycle, LSB nibble first.
// Define SUB32_OVF_EN to register signed overflow on ovf; otherwise ovf is tied low.
module sub32_serial
    import sub32_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = $clog2(NSLICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               accept;
    logic               last_slice;

    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_slice = (state == ST_RUN) && (cnt == CNT_LAST);

    cla4 u_slice (
        .a  (opa[SLICE_W-1:0]),
        .b  (opb[SLICE_W-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = start ? ST_RUN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Subtraction runs as a + ~b + ~bin; sums enter the accumulator from the top so
    // the first (least significant) nibble ends up at the bottom after NSLICE shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= ~b;
            carry <= ~bin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            acc   <= {slice_s, acc[WIDTH-1:SLICE_W]};
            opa   <= opa >> SLICE_W;
            opb   <= opb >> SLICE_W;
            carry <= slice_co;
            cnt   <= cnt + 1'b1;
            if (last_slice) begin
                diff <= {slice_s, acc[WIDTH-1:SLICE_W]};
                bout <= ~slice_co;
            end
        end
    end

`ifdef SUB32_OVF_EN
    logic sa;
    logic sb;

    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= 1'b0;
            sb  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (accept) begin
                sa <= a[WIDTH-1];
                sb <= b[WIDTH-1];
            end
            if (last_slice) begin
                ovf <= (sa ^ sb) & (slice_s[SLICE_W-1] ^ sa);
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sub32_serial.sv
// Directed self-checking bench for sub32_serial; expected values are hand-computed.
module tb_sub32_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    int checks;
    int failures;

`ifdef SUB32_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    sub32_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns 1ns after the accepting edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic bv_in);
        @(negedge clk);
        a     = av;
        b     = bv;
        bin   = bv_in;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded); returns 99 on timeout.
    task automatic wait_done(output int edges);
        edges = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, bout, ovf} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=0000", {busy, done, bout, ovf});
        end
        checks++;
        if (diff !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_diff got=%h exp=00000000", diff);
        end
    endtask

    task automatic test_basic;
        int edges;
        start_op(32'h5, 32'h3, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_busy got=%b exp=1", busy);
        end
        wait_done(edges);
        checks++;
        if (edges != 8) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d exp=8", edges);
        end
        checks++;
        if ({diff, bout, ovf, busy} !== {32'h2, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL basic_result got=%h/%b/%b/%b exp=00000002/0/0/0", diff, bout, ovf, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, diff} !== {1'b0, 1'b0, 32'h2}) begin
            failures++;
            $display("[TB] FAIL basic_pulse got=%b/%b/%h exp=0/0/00000002", done, busy, diff);
        end
    endtask

    task automatic test_patterns;
        logic [31:0] ta   [6] = '{32'h0, 32'h80000000, 32'hF, 32'h12345678, 32'h7FFFFFFF, 32'hFFFFFFFF};
        logic [31:0] tb   [6] = '{32'h1, 32'h1, 32'h1, 32'h87654321, 32'hFFFFFFFF, 32'h0};
        logic        tbi  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ed   [6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hD, 32'h8ACF1357, 32'h80000000, 32'hFFFFFFFE};
        logic        eb   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo   [6] = '{1'b0, OVF_ON, 1'b0, OVF_ON, OVF_ON, 1'b0};
        int edges;
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i], tbi[i]);
            wait_done(edges);
            checks++;
            if ({diff, bout, ovf} !== {ed[i], eb[i], eo[i]} || edges != 8) begin
                failures++;
                $display("[TB] FAIL pattern%0d got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=8",
                         i, diff, bout, ovf, edges, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int edges;
        start_op(32'h10, 32'h10, 1'b1);
        wait_done(edges);
        checks++;
        if ({diff, bout, ovf} !== {32'hFFFFFFFF, 1'b1, 1'b0} || edges != 8) begin
            failures++;
            $display("[TB] FAIL b2b_first got=%h/%b/%b lat=%0d exp=ffffffff/1/0 lat=8", diff, bout, ovf, edges);
        end
        a     = 32'hFFFFFFFF;
        b     = 32'hF;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({done, busy, diff} !== {1'b0, 1'b1, 32'hFFFFFFFF}) begin
            failures++;
            $display("[TB] FAIL b2b_accept got=%b/%b/%h exp=0/1/ffffffff", done, busy, diff);
        end
        wait_done(edges);
        checks++;
        if ({diff, bout, ovf} !== {32'hFFFFFFF0, 1'b0, 1'b0} || edges != 8) begin
            failures++;
            $display("[TB] FAIL b2b_second got=%h/%b/%b lat=%0d exp=fffffff0/0/0 lat=8", diff, bout, ovf, edges);
        end
    endtask

    task automatic test_start_ignored;
        int edges;
        start_op(32'h9, 32'h4, 1'b0);
        @(posedge clk);
        #1;
        a     = 32'h1;
        b     = 32'h1;
        bin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        checks++;
        if (edges != 6) begin
            failures++;
            $display("[TB] FAIL ignore_latency got=%0d exp=6", edges);
        end
        checks++;
        if ({diff, bout} !== {32'h5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL ignore_result got=%h/%b exp=00000005/0", diff, bout);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        int edges;
        int spurious;
        start_op(32'h9, 32'h4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, bout, ovf, diff} !== {4'b0000, 32'h0}) begin
            failures++;
            $display("[TB] FAIL abort_state got=%b%b%b%b/%h exp=0000/00000000", busy, done, bout, ovf, diff);
        end
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("[TB] FAIL abort_quiet got=%0d exp=0", spurious);
        end
        start_op(32'h12345678, 32'h02345678, 1'b0);
        wait_done(edges);
        checks++;
        if ({diff, bout, ovf} !== {32'h10000000, 1'b0, 1'b0} || edges != 8) begin
            failures++;
            $display("[TB] FAIL abort_restart got=%h/%b/%b lat=%0d exp=10000000/0/0 lat=8", diff, bout, ovf, edges);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
